// File: rtl/load_wb_arbiter.sv
// load_wb_arbiter: writeback arbiter for load results coming out of MEM/WB.
// Load results are queued in a DEPTH-entry FIFO. They share the single PRF
// write port and the single ROB completion port with the integer pipe, and the
// integer pipe always wins. load_wb_stall_o throttles the memblock early enough
// to absorb the two loads that may already be in flight.
// Optional feature: define LOAD_WB_BYPASS_EN to let a load reach the write ports
// in its arrival cycle when the FIFO is empty and the integer pipe is idle.
module load_wb_arbiter #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ROBID_W = 7,
  parameter int unsigned PREG_W  = 6,
  parameter int unsigned DATA_W  = 64
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               flush_valid_i,
  input  logic               memwb_instr_valid_i,
  input  logic [ROBID_W-1:0] memwb_robid_i,
  input  logic [PREG_W-1:0]  memwb_prd_i,
  input  logic               memwb_need_to_wb_i,
  input  logic               memwb_mmio_valid_i,
  input  logic [DATA_W-1:0]  memwb_opload_rddata_i,
  input  logic               intwb_valid_i,
  input  logic [ROBID_W-1:0] intwb_robid_i,
  input  logic [PREG_W-1:0]  intwb_prd_i,
  input  logic               intwb_need_to_wb_i,
  input  logic [DATA_W-1:0]  intwb_result_i,
  output logic               prf_wen_o,
  output logic [PREG_W-1:0]  prf_waddr_o,
  output logic [DATA_W-1:0]  prf_wdata_o,
  output logic               rob_cmpl_valid_o,
  output logic [ROBID_W-1:0] rob_cmpl_robid_o,
  output logic               rob_cmpl_mmio_o,
  output logic               load_wb_stall_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(DEPTH - 2);

  typedef struct packed {
    logic [ROBID_W-1:0] robid;
    logic [PREG_W-1:0]  prd;
    logic               need_wb;
    logic               mmio;
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t in_entry;
  entry_t head;
  logic   fifo_empty;
  logic   fifo_full;
  logic   bypass;
  logic   push_req;
  logic   pop;
  logic   wr_en;

  assign in_entry = '{robid:   memwb_robid_i,
                      prd:     memwb_prd_i,
                      need_wb: memwb_need_to_wb_i,
                      mmio:    memwb_mmio_valid_i,
                      data:    memwb_opload_rddata_i};

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_LVL);

`ifdef LOAD_WB_BYPASS_EN
  // Idle write port and nothing queued: the arriving load can go straight out.
  assign bypass = ~intwb_valid_i & fifo_empty & memwb_instr_valid_i & ~flush_valid_i;
`else
  assign bypass = 1'b0;
`endif

  // A flush kills both the incoming load and any head pop in the same cycle.
  assign push_req = memwb_instr_valid_i & ~flush_valid_i & ~bypass;
  assign pop      = ~intwb_valid_i & ~fifo_empty & ~flush_valid_i;
  // A full FIFO only accepts a push when the head leaves in the same cycle.
  assign wr_en    = push_req & (~fifo_full | pop);

  assign load_wb_stall_o = (count_q >= STALL_LVL);

  // Write-port mux: integer pipe first, then FIFO head, then bypassed load.
  // NOTE: every output gets a default before the if-chain so no latch is inferred.
  always_comb begin
    prf_wen_o        = 1'b0;
    prf_waddr_o      = '0;
    prf_wdata_o      = '0;
    rob_cmpl_valid_o = 1'b0;
    rob_cmpl_robid_o = '0;
    rob_cmpl_mmio_o  = 1'b0;
    if (intwb_valid_i) begin
      prf_wen_o        = intwb_need_to_wb_i;
      prf_waddr_o      = intwb_prd_i;
      prf_wdata_o      = intwb_result_i;
      rob_cmpl_valid_o = 1'b1;
      rob_cmpl_robid_o = intwb_robid_i;
    end else if (pop) begin
      prf_wen_o        = head.need_wb;
      prf_waddr_o      = head.prd;
      prf_wdata_o      = head.data;
      rob_cmpl_valid_o = 1'b1;
      rob_cmpl_robid_o = head.robid;
      rob_cmpl_mmio_o  = head.mmio;
    end else if (bypass) begin
      prf_wen_o        = in_entry.need_wb;
      prf_waddr_o      = in_entry.prd;
      prf_wdata_o      = in_entry.data;
      rob_cmpl_valid_o = 1'b1;
      rob_cmpl_robid_o = in_entry.robid;
      rob_cmpl_mmio_o  = in_entry.mmio;
    end
  end

  // Next-state for pointers and occupancy; flush returns everything to empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_valid_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  // Control state: pointers and occupancy count.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write.
  // NOTE: storage is deliberately not reset; an entry is only read after it is written.
  always_ff @(posedge clock_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_entry;
  end

`ifndef SYNTHESIS
  // A load arriving at a full FIFO with no pop is lost; the memblock broke the stall contract.
  overflow_drop_a: assert property (@(posedge clock_i) disable iff (!reset_n_i)
    !(push_req && fifo_full && !pop));
`endif

endmodule

// File: tb/tb_load_wb_arbiter.sv
// tb_load_wb_arbiter: directed scenarios plus randomized traffic for
// load_wb_arbiter, checked against a queue-based model of the writeback rules.
// Define LOAD_WB_BYPASS_EN to check the bypass build.
module tb_load_wb_arbiter;

  localparam int DEPTH   = 4;
  localparam int ROBID_W = 7;
  localparam int PREG_W  = 6;
  localparam int DATA_W  = 64;
  localparam int OW      = 1 + PREG_W + DATA_W + 1 + ROBID_W + 1 + 1;

  typedef struct packed {
    logic [ROBID_W-1:0] robid;
    logic [PREG_W-1:0]  prd;
    logic               need;
    logic               mmio;
    logic [DATA_W-1:0]  data;
  } ent_t;

  logic               clock;
  logic               reset_n;
  logic               flush_valid;
  logic               memwb_instr_valid;
  logic [ROBID_W-1:0] memwb_robid;
  logic [PREG_W-1:0]  memwb_prd;
  logic               memwb_need_to_wb;
  logic               memwb_mmio_valid;
  logic [DATA_W-1:0]  memwb_opload_rddata;
  logic               intwb_valid;
  logic [ROBID_W-1:0] intwb_robid;
  logic [PREG_W-1:0]  intwb_prd;
  logic               intwb_need_to_wb;
  logic [DATA_W-1:0]  intwb_result;
  logic               prf_wen;
  logic [PREG_W-1:0]  prf_waddr;
  logic [DATA_W-1:0]  prf_wdata;
  logic               rob_cmpl_valid;
  logic [ROBID_W-1:0] rob_cmpl_robid;
  logic               rob_cmpl_mmio;
  logic               load_wb_stall;

  int total = 0;
  int bad   = 0;

  // Reference model state: the queued loads in arrival order.
  ent_t q[$];
  logic [OW-1:0] exp_vec;
  bit   cur_iv, cur_lv, cur_fl, cur_bypassed;
  ent_t cur_le;

  load_wb_arbiter #(
    .DEPTH(DEPTH), .ROBID_W(ROBID_W), .PREG_W(PREG_W), .DATA_W(DATA_W)
  ) dut (
    .clock_i              (clock),
    .reset_n_i            (reset_n),
    .flush_valid_i        (flush_valid),
    .memwb_instr_valid_i  (memwb_instr_valid),
    .memwb_robid_i        (memwb_robid),
    .memwb_prd_i          (memwb_prd),
    .memwb_need_to_wb_i   (memwb_need_to_wb),
    .memwb_mmio_valid_i   (memwb_mmio_valid),
    .memwb_opload_rddata_i(memwb_opload_rddata),
    .intwb_valid_i        (intwb_valid),
    .intwb_robid_i        (intwb_robid),
    .intwb_prd_i          (intwb_prd),
    .intwb_need_to_wb_i   (intwb_need_to_wb),
    .intwb_result_i       (intwb_result),
    .prf_wen_o            (prf_wen),
    .prf_waddr_o          (prf_waddr),
    .prf_wdata_o          (prf_wdata),
    .rob_cmpl_valid_o     (rob_cmpl_valid),
    .rob_cmpl_robid_o     (rob_cmpl_robid),
    .rob_cmpl_mmio_o      (rob_cmpl_mmio),
    .load_wb_stall_o      (load_wb_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ent_t rand_ent();
    ent_t e;
    e.robid = ROBID_W'($urandom);
    e.prd   = PREG_W'($urandom);
    e.need  = 1'($urandom);
    e.mmio  = 1'($urandom);
    e.data  = {$urandom, $urandom};
    return e;
  endfunction

  function automatic ent_t mk_ent(int robid, int prd, bit need, bit mmio, logic [DATA_W-1:0] data);
    ent_t e;
    e.robid = ROBID_W'(robid);
    e.prd   = PREG_W'(prd);
    e.need  = need;
    e.mmio  = mmio;
    e.data  = data;
    return e;
  endfunction

  // Expected observation vector for a completing instruction; address/data are
  // don't-care when the PRF is not written, so they are zeroed on both sides.
  function automatic logic [OW-1:0] completion(ent_t e, bit is_load, bit stall);
    logic [PREG_W-1:0] a = e.need ? e.prd  : '0;
    logic [DATA_W-1:0] d = e.need ? e.data : '0;
    return {e.need, a, d, 1'b1, e.robid, is_load & e.mmio, stall};
  endfunction

  function automatic logic [OW-1:0] obs();
    logic [PREG_W-1:0] a = prf_waddr;
    logic [DATA_W-1:0] d = prf_wdata;
    if (rob_cmpl_valid && !prf_wen) begin
      a = '0;
      d = '0;
    end
    return {prf_wen, a, d, rob_cmpl_valid, rob_cmpl_robid, rob_cmpl_mmio, load_wb_stall};
  endfunction

  // Drive one cycle of inputs (at the falling edge) and predict the outputs.
  task automatic apply(input bit iv, input ent_t ie, input bit lv, input ent_t le, input bit fl);
    bit stall;
    intwb_valid         = iv;
    intwb_robid         = ie.robid;
    intwb_prd           = ie.prd;
    intwb_need_to_wb    = ie.need;
    intwb_result        = ie.data;
    memwb_instr_valid   = lv;
    memwb_robid         = le.robid;
    memwb_prd           = le.prd;
    memwb_need_to_wb    = le.need;
    memwb_mmio_valid    = le.mmio;
    memwb_opload_rddata = le.data;
    flush_valid         = fl;
    cur_iv = iv; cur_lv = lv; cur_fl = fl; cur_le = le;
    cur_bypassed = 1'b0;
    stall = (q.size() >= DEPTH - 2);
    exp_vec = {{(OW-1){1'b0}}, stall};
    if (iv) begin
      exp_vec = completion(ie, 1'b0, stall);
    end else if (!fl && q.size() > 0) begin
      exp_vec = completion(q[0], 1'b1, stall);
`ifdef LOAD_WB_BYPASS_EN
    end else if (!fl && lv) begin
      exp_vec = completion(le, 1'b1, stall);
      cur_bypassed = 1'b1;
`endif
    end
    #1;
  endtask

  // Advance one clock edge and update the model with the cycle's rules.
  task automatic tick();
    @(posedge clock);
    if (cur_fl) begin
      q.delete();
    end else begin
      if (!cur_iv && q.size() > 0) void'(q.pop_front());
      if (cur_lv && !cur_bypassed && q.size() < DEPTH) q.push_back(cur_le);
    end
    @(negedge clock);
  endtask

  task automatic apply_idle();
    apply(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    logic [OW-1:0] o;
    ent_t ld[3];
    // Idle under reset.
    reset_n = 1'b0;
    apply_idle();
    o = obs(); total++;
    if (o !== '0) begin bad++; $display("FAIL reset_idle got=%h want=0", o); end
    tick();
    reset_n = 1'b1;
    tick();
    // Queue three loads behind a busy integer pipe.
    for (int i = 0; i < 3; i++) begin
      ld[i] = rand_ent();
      apply(1'b1, rand_ent(), 1'b1, ld[i], 1'b0);
      o = obs(); total++;
      if (o !== exp_vec) begin bad++; $display("FAIL reset_fill%0d got=%h want=%h", i, o, exp_vec); end
      tick();
    end
    // Reset mid-traffic clears the queue and all outputs at once.
    q.delete();
    reset_n = 1'b0;
    apply_idle();
    o = obs(); total++;
    if (o !== '0) begin bad++; $display("FAIL reset_mid got=%h want=0", o); end
    tick();
    reset_n = 1'b1;
    apply_idle();
    o = obs(); total++;
    if (o !== '0) begin bad++; $display("FAIL reset_release got=%h want=0", o); end
    tick();
    // The first completion after release comes only from a new push.
    ld[0] = mk_ent(9, 3, 1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0);
    apply(1'b0, '0, 1'b1, ld[0], 1'b0);
    o = obs(); total++;
    if (o !== exp_vec) begin bad++; $display("FAIL reset_newpush got=%h want=%h", o, exp_vec); end
    tick();
    apply_idle();
    o = obs(); total++;
    if (o !== exp_vec) begin bad++; $display("FAIL reset_newpop got=%h want=%h", o, exp_vec); end
    tick();
  endtask

  task automatic test_single_load();
    logic [OW-1:0] o;
    ent_t ld = mk_ent(5, 12, 1'b1, 1'b0, 64'hDEAD_BEEF);
    apply(1'b0, '0, 1'b1, ld, 1'b0);
    o = obs(); total++;
    if (o !== exp_vec) begin bad++; $display("FAIL single_T got=%h want=%h", o, exp_vec); end
    tick();
    apply_idle();
    o = obs(); total++;
    if (o !== exp_vec) begin bad++; $display("FAIL single_T1 got=%h want=%h", o, exp_vec); end
`ifndef LOAD_WB_BYPASS_EN
    total++;
    if ({prf_wen, prf_waddr, prf_wdata, rob_cmpl_robid} !== {1'b1, 6'd12, 64'hDEAD_BEEF, 7'd5}) begin
      bad++;
      $display("FAIL single_ports got wen=%b waddr=%0d wdata=%h robid=%0d want 1/12/deadbeef/5",
               prf_wen, prf_waddr, prf_wdata, rob_cmpl_robid);
    end
`endif
    tick();
  endtask

  task automatic test_int_priority();
    logic [OW-1:0] o;
    ent_t ld[2];
    ld[0] = rand_ent();
    ld[1] = rand_ent();
    for (int c = 0; c < 4; c++) begin
      apply(1'b1, mk_ent(c + 40, c + 20, 1'b1, 1'b0, {$urandom, $urandom}),
            (c == 1 || c == 2), (c == 2) ? ld[1] : ld[0], 1'b0);
      o = obs(); total++;
      if (o !== exp_vec) begin bad++; $display("FAIL intprio_c%0d got=%h want=%h", c, o, exp_vec); end
      if (c == 3) begin
        total++;
        if (load_wb_stall !== 1'b1) begin bad++; $display("FAIL intprio_stall got=%b want=1", load_wb_stall); end
      end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      apply_idle();
      o = obs(); total++;
      if (o !== exp_vec) begin bad++; $display("FAIL intprio_drain%0d got=%h want=%h", c, o, exp_vec); end
      if (c < 2) begin
        total++;
        if (rob_cmpl_robid !== ld[c].robid) begin
          bad++; $display("FAIL intprio_order%0d got=%0d want=%0d", c, rob_cmpl_robid, ld[c].robid);
        end
      end
      tick();
    end
  endtask

  task automatic test_no_wb_mmio();
    logic [OW-1:0] o;
    apply(1'b0, '0, 1'b1, mk_ent(33, 7, 1'b0, 1'b1, 64'h55), 1'b0);
    o = obs(); total++;
    if (o !== exp_vec) begin bad++; $display("FAIL mmio_T got=%h want=%h", o, exp_vec); end
`ifdef LOAD_WB_BYPASS_EN
    total++;
    if ({prf_wen, rob_cmpl_valid, rob_cmpl_mmio} !== 3'b011) begin
      bad++; $display("FAIL mmio_flags got=%b want=011", {prf_wen, rob_cmpl_valid, rob_cmpl_mmio});
    end
`endif
    tick();
    apply_idle();
    o = obs(); total++;
    if (o !== exp_vec) begin bad++; $display("FAIL mmio_T1 got=%h want=%h", o, exp_vec); end
`ifndef LOAD_WB_BYPASS_EN
    total++;
    if ({prf_wen, rob_cmpl_valid, rob_cmpl_mmio} !== 3'b011) begin
      bad++; $display("FAIL mmio_flags got=%b want=011", {prf_wen, rob_cmpl_valid, rob_cmpl_mmio});
    end
`endif
    tick();
  endtask

  task automatic test_flush();
    logic [OW-1:0] o;
    ent_t ie;
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, rand_ent(), 1'b1, rand_ent(), 1'b0);
      o = obs(); total++;
      if (o !== exp_vec) begin bad++; $display("FAIL flush_fill%0d got=%h want=%h", c, o, exp_vec); end
      tick();
    end
    ie = mk_ent(77, 30, 1'b1, 1'b1, 64'hCAFE_F00D);
    apply(1'b1, ie, 1'b1, rand_ent(), 1'b1);
    o = obs(); total++;
    if (o !== exp_vec) begin bad++; $display("FAIL flush_cycle got=%h want=%h", o, exp_vec); end
    total++;
    if ({prf_wen, prf_waddr, rob_cmpl_robid, rob_cmpl_mmio} !== {1'b1, 6'd30, 7'd77, 1'b0}) begin
      bad++; $display("FAIL flush_int got wen=%b waddr=%0d robid=%0d mmio=%b want 1/30/77/0",
                      prf_wen, prf_waddr, rob_cmpl_robid, rob_cmpl_mmio);
    end
    tick();
    apply_idle();
    o = obs(); total++;
    if (o !== '0) begin bad++; $display("FAIL flush_after got=%h want=0", o); end
    tick();
  endtask

  task automatic test_streaming();
    logic [OW-1:0] o;
    for (int c = 0; c < 10; c++) begin
      apply(1'b0, '0, 1'b1, rand_ent(), 1'b0);
      o = obs(); total++;
      if (o !== exp_vec) begin bad++; $display("FAIL stream_c%0d got=%h want=%h", c, o, exp_vec); end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      apply_idle();
      o = obs(); total++;
      if (o !== exp_vec) begin bad++; $display("FAIL stream_drain%0d got=%h want=%h", c, o, exp_vec); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] o;
    bit iv, lv, fl;
    for (int c = 0; c < 400; c++) begin
      iv = ($urandom_range(99) < 50);
      lv = ($urandom_range(99) < 70) && (q.size() < DEPTH);
      fl = ($urandom_range(99) < 5);
      apply(iv, rand_ent(), lv, rand_ent(), fl);
      o = obs(); total++;
      if (o !== exp_vec) begin bad++; $display("FAIL random_c%0d got=%h want=%h", c, o, exp_vec); end
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    apply_idle();
    @(negedge clock);
    test_reset();
    test_single_load();
    test_int_priority();
    test_no_wb_mmio();
    test_flush();
    test_streaming();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
